// File: rtl/vga_pixel_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pixel_stream: buffers a valid/ready RGB pixel stream, replays it       |
// | against internally generated VGA timing.            Revision: 1.0          |
// +----------------------------------------------------------------------------+
module vga_pixel_stream #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_TOTAL  = 1040,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 38,
  parameter int V_SYNC   = 5,
  parameter int V_TOTAL  = 666,
  parameter int FIFO_AW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [2:0] s_rgb,
  input  logic       s_sof,
  output logic       h_sync,
  output logic       v_sync,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       frame_start,
  output logic       resync,
  output logic       underflow
);

  localparam int C_HW    = $clog2(H_TOTAL + 1);
  localparam int C_VW    = $clog2(V_TOTAL + 1);
  localparam int C_PW    = FIFO_AW + 1;
  localparam int C_DEPTH = 2 ** FIFO_AW;

  localparam logic [C_HW-1:0] C_H_ACT  = C_HW'(H_ACTIVE);
  localparam logic [C_HW-1:0] C_H_LAST = C_HW'(H_TOTAL - 1);
  localparam logic [C_HW-1:0] C_HS_BEG = C_HW'(H_ACTIVE + H_FP);
  localparam logic [C_HW-1:0] C_HS_END = C_HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [C_VW-1:0] C_V_ACT  = C_VW'(V_ACTIVE);
  localparam logic [C_VW-1:0] C_V_LAST = C_VW'(V_TOTAL - 1);
  localparam logic [C_VW-1:0] C_VS_BEG = C_VW'(V_ACTIVE + V_FP);
  localparam logic [C_VW-1:0] C_VS_END = C_VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {SEEK = 1'b0, STREAM = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [C_HW-1:0]   h_q, h_d;
  logic [C_VW-1:0]   v_q, v_d;
  logic [C_PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]        mem_q [C_DEPTH];
  logic              h_sync_q, h_sync_d;
  logic              v_sync_q, v_sync_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              frame_start_q, frame_start_d;
  logic              resync_q, resync_d;
  logic              underflow_q, underflow_d;

  logic              fifo_empty, fifo_full, push, pop;
  logic              active, at_origin;
  logic [3:0]        head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign s_ready    = !fifo_full && !rst;
  assign push       = s_valid && s_ready;
  assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign active     = (h_q < C_H_ACT) && (v_q < C_V_ACT);
  assign at_origin  = (h_q == '0) && (v_q == '0);

  always_comb begin
    h_d = h_q + C_HW'(1);
    v_d = v_q;
    if (h_q == C_H_LAST) begin
      h_d = '0;
      v_d = (v_q == C_V_LAST) ? '0 : v_q + C_VW'(1);
    end
  end

  // head[3] is the sof flag; a frame may only begin (and only be continued) in step with (0,0)
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    rgb_d       = 3'b000;
    resync_d    = 1'b0;
    underflow_d = underflow_q;
    case (state_q)
      SEEK: begin
        if (!fifo_empty) begin
          if (!head[3]) begin
            pop = 1'b1;
          end else if (at_origin) begin
            pop     = 1'b1;
            rgb_d   = head[2:0];
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (active) begin
          if (fifo_empty) begin
            underflow_d = 1'b1;
            resync_d    = 1'b1;
            state_d     = SEEK;
          end else if (head[3] == at_origin) begin
            pop   = 1'b1;
            rgb_d = head[2:0];
          end else begin
            resync_d = 1'b1;
            state_d  = SEEK;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q + C_PW'(push);
    rd_ptr_d      = rd_ptr_q + C_PW'(pop);
    h_sync_d      = !((h_q >= C_HS_BEG) && (h_q < C_HS_END));
    v_sync_d      = !((v_q >= C_VS_BEG) && (v_q < C_VS_END));
    frame_start_d = at_origin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEEK;
      h_q           <= '0;
      v_q           <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      rgb_q         <= 3'b000;
      frame_start_q <= 1'b0;
      resync_q      <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      resync_q      <= resync_d;
      underflow_q   <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {s_sof, s_rgb};
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign vga_r       = rgb_q[2];
  assign vga_g       = rgb_q[1];
  assign vga_b       = rgb_q[0];
  assign frame_start = frame_start_q;
  assign resync      = resync_q;
  assign underflow   = underflow_q;

endmodule
`default_nettype wire
